// File: rtl/loralite_pkg.sv
// Shared LoraLite receive definitions: CRC16-MODBUS constants, error codes and checker state encoding.
// Pure declarations: no latency and no flow control of its own.
package loralite_pkg;

  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_CRC     = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BODY,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } state_t;

  // One bit of the reflected CRC shift register.
  function automatic logic [15:0] crc_bit_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

endpackage

// File: rtl/loralite_crc_byte.sv
// Combinational CRC16-MODBUS update of one byte, eight unrolled shift steps; zero latency.
// No flow control: the caller decides when the result is registered.
module loralite_crc_byte
  import loralite_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [8:0][15:0] w_stage;

  assign w_stage[0] = i_crc ^ {8'h00, i_byte};

  for (genvar g = 0; g < 8; g++) begin : g_step
    assign w_stage[g+1] = crc_bit_step(w_stage[g]);
  end

  assign o_crc = w_stage[8];

endmodule

// File: rtl/loralite_frame_checker.sv
// LoraLite RX frame checker: forwards payload one cycle after acceptance, frame_done one cycle after CRC_HI/bad LEN.
// in_ready drops only for the single DONE cycle; LORALITE_FRMCHK_TIMEOUT_EN enables the inter-byte idle timeout.
module loralite_frame_checker
  import loralite_pkg::*;
#(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code,
  output logic [15:0] crc_rx
);

  // The byte counter is 8 bits and must never wrap.
  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("loralite_frame_checker: MAX_LEN must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("loralite_frame_checker: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      r_state;
  logic [15:0] r_crc;
  logic [7:0]  r_cnt;
  logic [7:0]  r_crc_lo;
  logic [15:0] r_crc_pend;
  logic [15:0] r_crc_rx;
  logic [7:0]  r_pl_data;
  logic        r_pl_valid;
  logic        r_pl_last;
  logic        r_ok;
  logic [1:0]  r_err;
  logic        r_in_ready;

  logic [15:0] w_crc_next;
  logic        w_accept;
  logic        w_frame_done;
  logic        w_timeout;

  loralite_crc_byte u_crc_byte (
    .i_crc  (r_crc),
    .i_byte (in_data),
    .o_crc  (w_crc_next)
  );

  assign w_accept     = in_valid & r_in_ready & ~abort;
  assign w_frame_done = (r_state == ST_DONE) & ~abort;

`ifdef LORALITE_FRMCHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_idle_cnt;
  logic          w_counting;

  assign w_counting = (r_state == ST_BODY) || (r_state == ST_CRC_LO) || (r_state == ST_CRC_HI);
  assign w_timeout  = w_counting & ~w_accept & ~abort &
                      (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (abort || w_accept || !w_counting || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_crc      <= CRC_INIT;
      r_cnt      <= 8'd0;
      r_crc_lo   <= 8'd0;
      r_crc_pend <= 16'h0000;
      r_crc_rx   <= 16'h0000;
      r_pl_data  <= 8'd0;
      r_pl_valid <= 1'b0;
      r_pl_last  <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= ERR_OK;
      r_in_ready <= 1'b1;
    end else begin
      r_pl_valid <= 1'b0;
      r_pl_last  <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= ERR_OK;
      r_in_ready <= 1'b1;

      if (abort) begin
        r_state <= ST_IDLE;
      end else if (w_timeout) begin
        r_state    <= ST_DONE;
        r_err      <= ERR_TIMEOUT;
        r_crc_pend <= r_crc_rx;
        r_in_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_crc <= CRC_INIT;
              r_cnt <= in_data;
              if (in_data > 8'(MAX_LEN)) begin
                r_state    <= ST_DONE;
                r_err      <= ERR_LEN;
                r_crc_pend <= r_crc_rx;
                r_in_ready <= 1'b0;
              end else if (in_data == 8'd0) begin
                r_state <= ST_CRC_LO;
              end else begin
                r_state <= ST_BODY;
              end
            end
          end

          ST_BODY: begin
            if (w_accept) begin
              r_crc      <= w_crc_next;
              r_cnt      <= r_cnt - 8'd1;
              r_pl_valid <= 1'b1;
              r_pl_data  <= in_data;
              if (r_cnt == 8'd1) begin
                r_pl_last <= 1'b1;
                r_state   <= ST_CRC_LO;
              end
            end
          end

          ST_CRC_LO: begin
            if (w_accept) begin
              r_crc    <= w_crc_next;
              r_crc_lo <= in_data;
              r_state  <= ST_CRC_HI;
            end
          end

          ST_CRC_HI: begin
            if (w_accept) begin
              r_crc      <= w_crc_next;
              r_crc_pend <= {in_data, r_crc_lo};
              r_ok       <= (w_crc_next == 16'h0000);
              r_err      <= (w_crc_next == 16'h0000) ? ERR_OK : ERR_CRC;
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
            end
          end

          ST_DONE: begin
            // Publish the received CRC only for a frame that actually reports done.
            r_crc_rx <= r_crc_pend;
            r_state  <= ST_IDLE;
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign pl_data    = r_pl_data;
  assign pl_valid   = r_pl_valid;
  assign pl_last    = r_pl_last;
  assign frame_done = w_frame_done;
  assign frame_ok   = r_ok;
  assign err_code   = r_err;
  // An aborted DONE cycle leaves the previously reported CRC on crc_rx.
  assign crc_rx     = w_frame_done ? r_crc_pend : r_crc_rx;

endmodule

// File: tb/tb_loralite_frame_checker.sv
// Randomized frame stimulus against a whole-message CRC16-MODBUS reference model and expectation queues.
module tb_loralite_frame_checker;

  localparam int MAX_LEN = 64;
  localparam int TO      = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [15:0] crc_rx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_cnt = 0;
  bit win = 1'b0;

  typedef struct {
    logic [7:0] dat;
    logic       last;
  } exp_pl_t;

  typedef struct {
    logic        ok;
    logic [1:0]  err;
    logic [15:0] crc;
    int          cyc;
  } exp_fr_t;

  exp_pl_t     pl_q[$];
  exp_fr_t     fr_q[$];
  exp_pl_t     m_pl;
  exp_fr_t     m_fr;
  logic [15:0] last_crc_rx = 16'h0000;

  loralite_frame_checker #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_last    (pl_last),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_code   (err_code),
    .crc_rx     (crc_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // CRC16-MODBUS of a whole message, bit-serial, as the protocol defines it.
  function automatic logic [15:0] crc16(input logic [7:0] msg[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (msg[i]) begin
      c = c ^ {8'h00, msg[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Monitor: sampled just after the falling edge, after the driver has queued its expectations.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (win && !in_ready) low_cnt++;
      if (pl_valid) begin
        if (pl_q.size() == 0) check("pl_unexpected", pl_q.size(), 1);
        else begin
          m_pl = pl_q.pop_front();
          check("pl_data", pl_data, m_pl.dat);
          check("pl_last", pl_last, m_pl.last);
        end
      end
      if (frame_done) begin
        if (fr_q.size() == 0) check("done_unexpected", fr_q.size(), 1);
        else begin
          m_fr = fr_q.pop_front();
          check("frame_ok", frame_ok, m_fr.ok);
          check("err_code", err_code, m_fr.err);
          check("crc_rx", crc_rx, m_fr.crc);
          check("done_cycle", cyc, m_fr.cyc);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int g;
    g = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("in_ready_stuck", in_ready, 1);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic push_payload(input logic [7:0] pay[$], input int len, input int upto);
    for (int i = 0; i < upto; i++) pl_q.push_back('{dat: pay[i], last: (i == len - 1)});
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$],
                            input logic [7:0] lo, input logic [7:0] hi, input int max_gap);
    int a;
    logic ok;
    if (int'(len) > MAX_LEN) begin
      send_byte(len, a);
      fr_q.push_back('{ok: 1'b0, err: 2'b10, crc: last_crc_rx, cyc: a});
      return;
    end
    push_payload(pay, int'(len), int'(len));
    send_byte(len, a);
    gap($urandom_range(max_gap, 0));
    for (int i = 0; i < int'(len); i++) begin
      send_byte(pay[i], a);
      gap($urandom_range(max_gap, 0));
    end
    send_byte(lo, a);
    gap($urandom_range(max_gap, 0));
    send_byte(hi, a);
    ok = (crc16(pay) == {hi, lo});
    last_crc_rx = {hi, lo};
    fr_q.push_back('{ok: ok, err: (ok ? 2'b00 : 2'b01), crc: {hi, lo}, cyc: a});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] p1[$];
    logic [7:0] none[$];
    logic [7:0] pr[$];
    logic [15:0] c;
    int a;
    int len;

    p1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_pl_valid", pl_valid, 0);
    check("rst_pl_last", pl_last, 0);
    check("rst_pl_data", pl_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_err_code", err_code, 0);
    check("rst_crc_rx", crc_rx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(8'd9, p1, 8'h37, 8'h4B, 0);
    gap(3);
    send_frame(8'd9, p1, 8'h37, 8'h4C, 1);
    gap(3);
    send_frame(8'h41, none, 8'h00, 8'h00, 0);
    send_frame(8'd9, p1, 8'h37, 8'h4B, 0);
    gap(3);
    send_frame(8'd0, none, 8'hFF, 8'hFF, 0);
    gap(3);

    // Back-to-back frames with in_valid never dropped.
    low_cnt = 0;
    win = 1'b1;
    send_frame(8'd9, p1, 8'h37, 8'h4B, 0);
    send_frame(8'd9, p1, 8'h37, 8'h4B, 0);
    gap(3);
    win = 1'b0;
    check("in_ready_low_cycles", low_cnt, 2);

    // Abort after four payload bytes.
    push_payload(p1, 9, 4);
    send_byte(8'd9, a);
    for (int i = 0; i < 4; i++) send_byte(p1[i], a);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    send_frame(8'd9, p1, 8'h37, 8'h4B, 0);
    gap(3);

    // Abort during DONE suppresses frame_done and keeps the old crc_rx.
    push_payload(p1, 9, 9);
    send_byte(8'd9, a);
    for (int i = 0; i < 9; i++) send_byte(p1[i], a);
    send_byte(8'h11, a);
    send_byte(8'h22, a);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    gap(2);
    send_frame(8'd200, none, 8'h00, 8'h00, 0);
    gap(3);

    // Long stall mid-body.
`ifdef LORALITE_FRMCHK_TIMEOUT_EN
    push_payload(p1, 9, 3);
    send_byte(8'd9, a);
    for (int i = 0; i < 3; i++) send_byte(p1[i], a);
    fr_q.push_back('{ok: 1'b0, err: 2'b11, crc: last_crc_rx, cyc: a + TO});
    gap(TO + 4);
`else
    push_payload(p1, 9, 9);
    send_byte(8'd9, a);
    for (int i = 0; i < 3; i++) send_byte(p1[i], a);
    gap(40);
    for (int i = 3; i < 9; i++) send_byte(p1[i], a);
    send_byte(8'h37, a);
    send_byte(8'h4B, a);
    last_crc_rx = 16'h4B37;
    fr_q.push_back('{ok: 1'b1, err: 2'b00, crc: 16'h4B37, cyc: a});
    gap(3);
`endif

    // Reset in the middle of a frame.
    push_payload(p1, 5, 2);
    send_byte(8'd5, a);
    send_byte(p1[0], a);
    send_byte(p1[1], a);
    gap(1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_pl_valid", pl_valid, 0);
    check("midrst_crc_rx", crc_rx, 0);
    last_crc_rx = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(72, 0);
      pr.delete();
      for (int i = 0; i < len; i++) pr.push_back(8'($urandom_range(255, 0)));
      c = crc16(pr);
      if ($urandom_range(3, 0) == 0) c = c ^ (16'h0001 << $urandom_range(15, 0));
      send_frame(8'(len), pr, c[7:0], c[15:8], 2);
      gap($urandom_range(2, 0));
    end
    gap(5);

    check("pl_queue_drained", pl_q.size(), 0);
    check("frame_queue_drained", fr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
